// File: rtl/tx_sched_4b5b.sv
// Round-robin scheduler sharing one 4b5b-encoded UART transmit line between N_REQ byte sources.
// Frame on the line, LSB first: start(0), low-nibble symbol b0..b4, high-nibble symbol b0..b4, stop(1).
module tx_sched_4b5b #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned BIT_CYCLES = 109,
  parameter int unsigned GAP_BITS   = 1
) (
  input  logic                 CLK_50M,
  input  logic                 RST,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 TXD,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

  localparam int unsigned FRAME_BITS = 12;
  localparam int unsigned GAP_CYCLES = GAP_BITS * BIT_CYCLES;
  localparam int unsigned BAUD_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned EXT_W      = 1 << ID_W;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(FRAME_BITS - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t                  state;
  logic [ID_W-1:0]         ptr;
  logic [ID_W-1:0]         win;
  logic [FRAME_BITS-1:0]   frame;
  logic [3:0]              bit_cnt;
  logic [BAUD_W-1:0]       baud_cnt;
  logic [GAP_W-1:0]        gap_cnt;

  logic [EXT_W-1:0]        valid_ext;
  logic [ID_W-1:0]         cand;
  logic [ID_W-1:0]         scan_win;
  logic                    scan_hit;
  logic [7:0]              win_byte;
  logic [N_REQ-1:0]        ready_nxt;

  function automatic logic [4:0] enc5(input logic [3:0] nib);
    case (nib)
      4'h0: enc5 = 5'b11110;
      4'h1: enc5 = 5'b01001;
      4'h2: enc5 = 5'b10100;
      4'h3: enc5 = 5'b10101;
      4'h4: enc5 = 5'b01010;
      4'h5: enc5 = 5'b01011;
      4'h6: enc5 = 5'b01110;
      4'h7: enc5 = 5'b01111;
      4'h8: enc5 = 5'b10010;
      4'h9: enc5 = 5'b10011;
      4'hA: enc5 = 5'b10110;
      4'hB: enc5 = 5'b10111;
      4'hC: enc5 = 5'b11010;
      4'hD: enc5 = 5'b11011;
      4'hE: enc5 = 5'b11100;
      4'hF: enc5 = 5'b11101;
    endcase
  endfunction

  // Zero-extended so a requester index of ID_W bits always selects in range.
  assign valid_ext = EXT_W'(req_valid);

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    scan_hit = 1'b0;
    scan_win = ptr;
    cand     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ID_W'((32'(ptr) + k) % N_REQ);
      if (!scan_hit && valid_ext[cand]) begin
        scan_hit = 1'b1;
        scan_win = cand;
      end
    end
  end

  always_comb begin
    win_byte  = '0;
    ready_nxt = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == win) begin
        win_byte     = req_data[8*k +: 8];
        ready_nxt[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state     <= S_IDLE;
      ptr       <= '0;
      win       <= '0;
      grant_id  <= '0;
      req_ready <= '0;
      busy      <= 1'b0;
      TXD       <= 1'b1;
      frame     <= '1;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        S_IDLE: begin
          TXD <= 1'b1;
          if (scan_hit) begin
            win   <= scan_win;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        // Winner is re-qualified here; a requester that withdrew is skipped without moving ptr.
        S_LOAD: begin
          if (valid_ext[win]) begin
            req_ready <= ready_nxt;
            frame     <= {1'b1, enc5(win_byte[7:4]), enc5(win_byte[3:0]), 1'b0};
            grant_id  <= win;
            ptr       <= (win == LAST_ID) ? '0 : win + 1'b1;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            state     <= S_SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          TXD <= frame[bit_cnt];
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              gap_cnt <= '0;
              if (GAP_CYCLES == 0) begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end else begin
                state <= S_GAP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_GAP: begin
          TXD <= 1'b1;
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
